riscv_test_monitor: RTL and testbench



---
 rtl/riscv_test_monitor_if.sv | 11 +
 rtl/riscv_test_monitor.sv | 160 ++++++++++++++++
 tb/tb_riscv_test_monitor.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_test_monitor_if.sv
// Register-file write-port snoop bundle shared by the core side and the test monitor.
interface riscv_test_monitor_if #(
  parameter int XLEN = 32
);
  logic            rd_we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_wdata;

  modport master (output rd_we, rd_addr, rd_wdata);
  modport slave  (input  rd_we, rd_addr, rd_wdata);
endinterface

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: shadows testnum/done/result registers from the regfile write port.
// Optional cycle counter enabled by macro TEST_MON_CYCLE_CNT_EN (otherwise cycle_count is 0).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | test executing, watching for done write or timeout
// DRAIN | done seen, counting down before sampling result
// DONE  | verdict latched and held
module riscv_test_monitor #(
  parameter int XLEN           = 32,
  parameter int TESTNUM_REG    = 3,
  parameter int DONE_REG       = 26,
  parameter int RESULT_REG     = 27,
  parameter int PASS_VALUE     = 1,
  parameter int DRAIN_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  riscv_test_monitor_if.slave  snoop,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [XLEN-1:0]      fail_testnum,
  output logic [CNT_W-1:0]     cycle_count
);

  localparam logic [4:0]      TESTNUM_IDX = 5'(TESTNUM_REG);
  localparam logic [4:0]      DONE_IDX    = 5'(DONE_REG);
  localparam logic [4:0]      RESULT_IDX  = 5'(RESULT_REG);
  localparam logic [XLEN-1:0] PASS_V      = XLEN'(PASS_VALUE);
  localparam logic [7:0]      DRAIN_LAST  = 8'(DRAIN_CYCLES - 1);
  localparam bit              TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0]     TO_LAST     = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [31:0]     run_cnt, run_nx;
  logic [7:0]      drain_cnt, drain_nx;
  logic [XLEN-1:0] testnum_q, testnum_nx;
  logic [XLEN-1:0] result_q, result_nx;
  logic            busy_nx, done_nx, pass_nx, fail_nx, timeout_nx;
  logic [XLEN-1:0] ftn_nx;
  logic            snoop_en, wr_ok, done_hit;

  assign snoop_en = (state == RUN) || (state == DRAIN);
  assign wr_ok    = snoop_en && snoop.rd_we && (snoop.rd_addr != 5'd0);
  assign done_hit = wr_ok && (snoop.rd_addr == DONE_IDX) && (snoop.rd_wdata != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      run_cnt      <= '0;
      drain_cnt    <= '0;
      testnum_q    <= '0;
      result_q     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else begin
      state        <= state_nx;
      run_cnt      <= run_nx;
      drain_cnt    <= drain_nx;
      testnum_q    <= testnum_nx;
      result_q     <= result_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      pass         <= pass_nx;
      fail         <= fail_nx;
      timeout      <= timeout_nx;
      fail_testnum <= ftn_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    run_nx     = run_cnt;
    drain_nx   = drain_cnt;
    testnum_nx = testnum_q;
    result_nx  = result_q;
    done_nx    = done;
    pass_nx    = pass;
    fail_nx    = fail;
    timeout_nx = timeout;
    ftn_nx     = fail_testnum;

    // Verdicts below read the *_nx shadows so a write on the deciding edge still counts.
    if (wr_ok && snoop.rd_addr == TESTNUM_IDX) testnum_nx = snoop.rd_wdata;
    if (wr_ok && snoop.rd_addr == RESULT_IDX)  result_nx  = snoop.rd_wdata;

    if (start) begin
      state_nx   = RUN;
      run_nx     = '0;
      drain_nx   = '0;
      testnum_nx = '0;
      result_nx  = '0;
      done_nx    = 1'b0;
      pass_nx    = 1'b0;
      fail_nx    = 1'b0;
      timeout_nx = 1'b0;
      ftn_nx     = '0;
    end else begin
      case (state)
        RUN: begin
          if (done_hit) begin
            state_nx = DRAIN;
            drain_nx = DRAIN_LAST;
          end else if (TIMEOUT_EN && run_cnt == TO_LAST) begin
            state_nx   = DONE;
            done_nx    = 1'b1;
            timeout_nx = 1'b1;
            fail_nx    = 1'b1;
            pass_nx    = 1'b0;
            ftn_nx     = testnum_nx;
          end else if (run_cnt != '1) begin
            run_nx = run_cnt + 32'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 8'd0) begin
            state_nx = DONE;
            done_nx  = 1'b1;
            pass_nx  = (result_nx == PASS_V);
            fail_nx  = (result_nx != PASS_V);
            ftn_nx   = (result_nx == PASS_V) ? '0 : testnum_nx;
          end else begin
            drain_nx = drain_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end

    busy_nx = (state_nx == RUN) || (state_nx == DRAIN);
  end

`ifdef TEST_MON_CYCLE_CNT_EN
  logic [CNT_W-1:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst || start)
      cyc_q <= '0;
    else if (snoop_en && cyc_q != '1)
      cyc_q <= cyc_q + 1'b1;
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed self-checking bench for riscv_test_monitor (TIMEOUT_CYCLES=50, DRAIN_CYCLES=10).
module tb_riscv_test_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, pass, fail, timeout;
  logic [31:0] fail_testnum;
  logic [31:0] cycle_count;
  int          n_checks = 0;
  int          n_errors = 0;
  int          lat;

  riscv_test_monitor_if #(.XLEN(32)) snoop_if ();

  riscv_test_monitor #(
    .XLEN(32), .TESTNUM_REG(3), .DONE_REG(26), .RESULT_REG(27), .PASS_VALUE(1),
    .DRAIN_CYCLES(10), .TIMEOUT_CYCLES(50), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .snoop(snoop_if),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_testnum(fail_testnum), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    snoop_if.rd_we = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    snoop_if.rd_we    = 1'b1;
    snoop_if.rd_addr  = addr;
    snoop_if.rd_wdata = data;
    tick();
    snoop_if.rd_we    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    snoop_if.rd_we = 1'b0; snoop_if.rd_addr = '0; snoop_if.rd_wdata = '0;
    repeat (3) tick();
    check_val("rst_done", done, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_pass_fail", {pass, fail, timeout}, 0);
    check_val("rst_ftn", fail_testnum, 0);
    check_val("rst_cyc", cycle_count, 0);
    rst = 1'b0;
    tick();

    // basic pass
    pulse_start();
    check_val("t1_busy", busy, 1);
    do_write(5'd3, 32'd5);
    do_write(5'd27, 32'd1);
    do_write(5'd26, 32'd1);
    check_val("t1_nodone_e0", done, 0);
    wait_done(20, lat);
    check_val("t1_latency", lat, 10);
    check_val("t1_pass", pass, 1);
    check_val("t1_fail", fail, 0);
    check_val("t1_ftn", fail_testnum, 0);
    check_val("t1_busy_off", busy, 0);
    check_val("t1_timeout", timeout, 0);

    // late result write in 9th drain cycle, pass then fail
    pulse_start();
    check_val("t2_cleared", {done, pass, fail}, 0);
    do_write(5'd3, 32'd7);
    do_write(5'd26, 32'd1);
    idle(8);
    do_write(5'd27, 32'd1);
    wait_done(5, lat);
    check_val("t2a_latency", lat, 1);
    check_val("t2a_pass", pass, 1);
    check_val("t2a_ftn", fail_testnum, 0);

    pulse_start();
    do_write(5'd3, 32'd7);
    do_write(5'd26, 32'd1);
    idle(8);
    do_write(5'd27, 32'd0);
    wait_done(5, lat);
    check_val("t2b_latency", lat, 1);
    check_val("t2b_pass", pass, 0);
    check_val("t2b_fail", fail, 1);
    check_val("t2b_ftn", fail_testnum, 7);

    // timeout at RUN cycle 50
    pulse_start();
    do_write(5'd3, 32'd2);
    wait_done(100, lat);
    check_val("t3_latency", lat, 49);
    check_val("t3_timeout", timeout, 1);
    check_val("t3_fail", fail, 1);
    check_val("t3_pass", pass, 0);
    check_val("t3_ftn", fail_testnum, 2);
    check_val("t3_busy", busy, 0);

    // done write coinciding with timeout terminal count: done wins
    pulse_start();
    idle(49);
    do_write(5'd26, 32'd1);
    check_val("tc_busy", busy, 1);
    check_val("tc_no_timeout", {done, timeout}, 0);
    wait_done(20, lat);
    check_val("tc_latency", lat, 10);
    check_val("tc_verdict", {pass, fail, timeout}, 3'b010);

    // ignored writes, then reset mid-drain
    pulse_start();
    do_write(5'd0, 32'd1);
    do_write(5'd26, 32'd0);
    idle(5);
    check_val("t4_busy", busy, 1);
    check_val("t4_no_done", done, 0);
    do_write(5'd3, 32'd9);
    do_write(5'd26, 32'd1);
    idle(3);
    check_val("t4_drain_busy", busy, 1);
    rst = 1'b1;
    tick();
    check_val("t4_rst_outs", {busy, done, pass, fail, timeout}, 0);
    check_val("t4_rst_ftn", fail_testnum, 0);
    rst = 1'b0;
    idle(15);
    check_val("t4_idle", {busy, done}, 0);

    // writes after verdict ignored; start clears outputs
    pulse_start();
    do_write(5'd27, 32'd0);
    do_write(5'd26, 32'd1);
    wait_done(20, lat);
    check_val("t5_fail", {pass, fail}, 2'b01);
    do_write(5'd27, 32'd1);
    do_write(5'd26, 32'd1);
    idle(2);
    check_val("t5_held", {done, pass, fail}, 3'b101);
    pulse_start();
    check_val("t5_cleared", {done, pass, fail, busy}, 4'b0001);
    do_write(5'd27, 32'd1);
    do_write(5'd26, 32'd1);
    wait_done(20, lat);
    check_val("t5_second_pass", {pass, fail}, 2'b10);

    // cycle counter: done at RUN cycle 20, drain 10
    pulse_start();
    idle(19);
    do_write(5'd26, 32'd1);
    wait_done(20, lat);
    check_val("t6_latency", lat, 10);
`ifdef TEST_MON_CYCLE_CNT_EN
    check_val("t6_cyc", cycle_count, 30);
    idle(3);
    check_val("t6_cyc_frozen", cycle_count, 30);
`else
    check_val("t6_cyc", cycle_count, 0);
    idle(3);
    check_val("t6_cyc_frozen", cycle_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
